sliding_window_queue: RTL and testbench

//  Parametrised successor of the high-frequency sample queue. Holds the last TAPS

---
 rtl/sliding_window_queue.sv | 117 +++++++++++
 tb/tb_sliding_window_queue.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/sliding_window_queue.sv
// Circular sample window for CH parallel channels; after every accepted sample the
// last TAPS samples are streamed oldest-to-newest to the downstream MAC engines.
module sliding_window_queue #(
  parameter int unsigned DW    = 16,
  parameter int unsigned CH    = 2,
  parameter int unsigned DEPTH = 1536,
  parameter int unsigned TAPS  = 1531
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wrt_smpl,
  input  logic [CH*DW-1:0]   new_smpl,
  input  logic               flush,
  output logic [CH*DW-1:0]   smpl_out,
  output logic               smpl_vld,
  output logic               sequencing,
  output logic               full,
  output logic               overrun
);

  localparam int unsigned WW = CH * DW;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(TAPS + 1);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    IDLE = 2'd1,
    SEQ  = 2'd2
  } state_t;

  state_t          state;
  logic [WW-1:0]   mem [DEPTH];
  logic [AW-1:0]   new_ptr;
  logic [AW-1:0]   old_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   rd_cnt;
  logic            wr_en;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Strobes arriving mid-burst are dropped, so the window being read never changes.
  assign wr_en = wrt_smpl && !rst && !flush && (state != SEQ);

  always_ff @(posedge clk) begin
    if (wr_en) mem[new_ptr] <= new_smpl;
  end

  // Synchronous RAM read port doubles as the output hold register.
  always_ff @(posedge clk) begin
    if (rst) begin
      smpl_out <= '0;
    end else if (state == SEQ && !flush) begin
      smpl_out <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state      <= FILL;
      new_ptr    <= '0;
      old_ptr    <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      rd_cnt     <= '0;
      sequencing <= 1'b0;
      smpl_vld   <= 1'b0;
      full       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      smpl_vld <= sequencing;
      overrun  <= 1'b0;
      case (state)
        FILL: begin
          if (wrt_smpl) begin
            new_ptr <= ptr_inc(new_ptr);
            cnt     <= cnt + CW'(1);
            if (cnt == CW'(TAPS - 1)) begin
              rd_ptr     <= old_ptr;
              rd_cnt     <= '0;
              full       <= 1'b1;
              sequencing <= 1'b1;
              state      <= SEQ;
            end
          end
        end
        IDLE: begin
          if (wrt_smpl) begin
            new_ptr    <= ptr_inc(new_ptr);
            old_ptr    <= ptr_inc(old_ptr);
            rd_ptr     <= ptr_inc(old_ptr);
            rd_cnt     <= '0;
            sequencing <= 1'b1;
            state      <= SEQ;
          end
        end
        SEQ: begin
          overrun <= wrt_smpl;
          rd_ptr  <= ptr_inc(rd_ptr);
          rd_cnt  <= rd_cnt + CW'(1);
          if (rd_cnt == CW'(TAPS - 1)) begin
            sequencing <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          sequencing <= 1'b0;
          state      <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sliding_window_queue.sv
// Bench for sliding_window_queue: directed scenarios plus random traffic, checked
// every cycle against a queue-based window model.
module tb_sliding_window_queue;

  localparam int unsigned DW    = 16;
  localparam int unsigned CH    = 2;
  localparam int unsigned DEPTH = 8;
  localparam int          TAPS  = 5;
  localparam int unsigned WW    = CH * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          wrt_smpl;
  logic [WW-1:0] new_smpl;
  logic          flush;
  logic [WW-1:0] smpl_out;
  logic          smpl_vld;
  logic          sequencing;
  logic          full;
  logic          overrun;

  always #5 clk = ~clk;

  sliding_window_queue #(
    .DW(DW), .CH(CH), .DEPTH(DEPTH), .TAPS(TAPS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wrt_smpl   (wrt_smpl),
    .new_smpl   (new_smpl),
    .flush      (flush),
    .smpl_out   (smpl_out),
    .smpl_vld   (smpl_vld),
    .sequencing (sequencing),
    .full       (full),
    .overrun    (overrun)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: window contents as a queue, snapshot of the burst being streamed.
  logic [WW-1:0] win[$];
  logic [WW-1:0] burst[$];
  int            seq_left = 0;
  logic [WW-1:0] exp_out  = '0;
  logic          exp_vld  = 1'b0;
  logic          exp_ovr  = 1'b0;

  task automatic check(input string tag, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", tag, act, exp, $time);
  endtask

  function automatic logic [WW-1:0] smp(input int k);
    return {16'(32'h0100 + k), 16'(k)};
  endfunction

  task automatic model_step(input logic r, input logic f, input logic w, input logic [WW-1:0] d);
    if (r) begin
      win.delete();
      seq_left = 0;
      exp_out  = '0;
      exp_vld  = 1'b0;
      exp_ovr  = 1'b0;
    end else if (f) begin
      win.delete();
      seq_left = 0;
      exp_vld  = 1'b0;
      exp_ovr  = 1'b0;
    end else begin
      exp_vld = (seq_left > 0);
      exp_ovr = w && (seq_left > 0);
      if (seq_left > 0) begin
        exp_out = burst[TAPS - seq_left];
        seq_left--;
      end else if (w) begin
        win.push_back(d);
        if (win.size() > TAPS) void'(win.pop_front());
        if (win.size() == TAPS) begin
          burst    = win;
          seq_left = TAPS;
        end
      end
    end
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare all outputs.
  task automatic cyc(input logic r, input logic f, input logic w, input logic [WW-1:0] d);
    rst      = r;
    flush    = f;
    wrt_smpl = w;
    new_smpl = d;
    @(posedge clk);
    #1;
    model_step(r, f, w, d);
    check("sequencing", WW'(sequencing), WW'(seq_left > 0));
    check("smpl_vld",   WW'(smpl_vld),   WW'(exp_vld));
    check("full",       WW'(full),       WW'(win.size() == TAPS));
    check("overrun",    WW'(overrun),    WW'(exp_ovr));
    check("smpl_out",   smpl_out,        exp_out);
    rst      = 1'b0;
    flush    = 1'b0;
    wrt_smpl = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic wr(input logic [WW-1:0] d, input int gap);
    cyc(1'b0, 1'b0, 1'b1, d);
    idle(gap);
  endtask

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    wrt_smpl = 1'b0;
    new_smpl = '0;

    // Reset, no writes
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, '0);
    idle(3);

    // Fill 1..5, then sliding bursts through pointer wrap
    for (int k = 1; k <= 13; k++) wr(smp(k), 7);

    // Strobe during a burst is dropped with an overrun pulse
    cyc(1'b0, 1'b0, 1'b1, smp(13));
    idle(2);
    cyc(1'b0, 1'b0, 1'b1, 32'h00EE_00EE);
    idle(6);
    wr(smp(14), 7);

    // Reset on third sequencing cycle, then refill 20..24
    cyc(1'b0, 1'b0, 1'b1, smp(15));
    idle(2);
    cyc(1'b1, 1'b0, 1'b0, '0);
    idle(2);
    for (int k = 20; k <= 24; k++) wr(smp(k), 7);

    // Flush colliding with a write in IDLE, then refill
    cyc(1'b0, 1'b1, 1'b1, smp(25));
    idle(3);
    for (int k = 26; k <= 30; k++) wr(smp(k), 7);
    wr(smp(31), 7);

    // Random traffic, including overruns, flushes and resets
    for (int i = 0; i < 600; i++) begin
      logic r, f, w;
      r = ($urandom_range(0, 249) == 0);
      f = ($urandom_range(0, 79) == 0);
      w = ($urandom_range(0, 3) == 0);
      cyc(r, f, w, WW'($urandom));
    end
    idle(TAPS + 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
